// File: rtl/mips_pkg.sv
// Shared processor constants and the boot loader state encoding.
package mips_pkg;

  localparam int unsigned IMEM_WORDS      = 64;
  localparam int unsigned IMEM_ADDR_WIDTH = 6;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StLoad,
    StDrain,
    StCheck,
    StDone,
    StError
  } loader_state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a byte stream into 32-bit big-endian words; word_valid_o pulses with byte 3.
module imem_word_assembler (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[15:0], byte_data_i};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  // Word completes combinationally with the fourth byte; the top registers it.
  always_comb begin
    word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);
    word_o       = {shift_q, byte_data_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader; holds the CPU until the program is written.
// Optional trailer checksum enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic                  ByteValid,
  input  logic [7:0]            ByteData,
  output logic                  ByteReady,
  output logic                  WriteEnable,
  output logic [ADDR_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  CpuHold,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);
  import mips_pkg::*;

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            acc_q, acc_d;
`endif

  logic        accept;
  logic        asm_clear;
  logic        asm_valid;
  logic        word_valid;
  logic [31:0] word;

  assign accept    = ByteValid && ByteReady;
  assign asm_valid = accept && (state_q == StLoad);

  imem_word_assembler u_asm (
    .clk_i        (clk),
    .reset_i      (reset),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_valid),
    .byte_data_i  (ByteData),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    asm_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    acc_d     = acc_q;
`endif
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (Start) begin
          state_d   = StHeader;
          idx_d     = '0;
          asm_clear = 1'b1;
        end
      end
      StHeader: begin
        if (accept) begin
          // Header 0 encodes a full memory image.
          last_d  = (ByteData == 8'd0) ? ADDR_WIDTH'(IMEM_WORDS - 1)
                                       : ADDR_WIDTH'(ByteData - 8'd1);
          state_d = StLoad;
`ifdef IMEM_LOADER_CHECKSUM_EN
          acc_d   = ByteData;
`endif
        end
      end
      StLoad: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) acc_d = acc_q + ByteData;
`endif
        if (word_valid) begin
          we_d    = 1'b1;
          waddr_d = idx_q;
          wdata_d = word;
          if (idx_q == last_q) state_d = StDrain;
          else                 idx_d   = idx_q + 1'b1;
        end
      end
      StDrain: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_d = StCheck;
`else
        state_d = StDone;
`endif
      end
      StCheck: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) state_d = (ByteData == acc_q) ? StDone : StError;
`else
        state_d = StDone;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ByteReady = (state_q == StHeader) || (state_q == StLoad) || (state_q == StCheck);
    Busy      = ByteReady || (state_q == StDrain);
    Done      = (state_q == StDone);
    CpuHold   = !Done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    Error     = (state_q == StError);
`else
    Error     = 1'b0;
`endif
    WriteEnable  = we_q;
    WriteAddress = waddr_q;
    WriteData    = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      last_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the processor's 64-word instruction memory. It accepts a byte stream over a valid/ready handshake, packs the bytes into 32-bit big-endian words, and drives the instruction memory write port. It holds the CPU in reset until the program is fully written. It sits between the host/UART byte source and the instruction memory write side, and owns the `CpuHold` signal that gates the core.

## Interface
Parameters:
- `IMEM_WORDS`, 64: instruction memory depth in words
- `ADDR_WIDTH`, 6: word address width; must equal log2(`IMEM_WORDS`)
- `DATA_WIDTH`, 32: instruction width; must be 4 × 8

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `Start`  in  1  begin a load; sampled only in IDLE, DONE and ERROR
- `ByteValid`  in  1  source has a byte on `ByteData`
- `ByteData`  in  8  stream byte
- `ByteReady`  out  1  loader accepts a byte this cycle
- `WriteEnable`  out  1  one-cycle instruction memory write strobe
- `WriteAddress`  out  `ADDR_WIDTH`  word address
- `WriteData`  out  `DATA_WIDTH`  assembled instruction
- `CpuHold`  out  1  holds the core in reset while 1
- `Busy`  out  1  a load is in progress
- `Done`  out  1  load completed successfully
- `Error`  out  1  load failed (checksum build only)

## Operation
- Stream format: 1 header byte N (word count; 1–63 literal, 0 means 64), then N words of 4 bytes each, MSB first. The checksum build appends 1 trailer byte.
- States and transitions:
  - IDLE → HEADER on `Start`
  - HEADER → LOAD on header byte accepted
  - LOAD → DRAIN on the 4th byte of word N−1
  - DRAIN → CHECK (checksum build) or DONE
  - CHECK → DONE on match; CHECK → ERROR on mismatch
  - DONE/ERROR → HEADER on `Start`
- A byte is accepted on an edge where `ByteValid && ByteReady`. `ByteReady` is 1 exactly in HEADER, LOAD and CHECK.
- Word assembly: byte k of a word (k = 0..3) lands in bits [31−8k : 24−8k]. The byte counter wraps 3→0.
- Word index starts at 0 and increments after each write. It never exceeds N−1, so there is no address wrap.
- `CpuHold` is 1 in every state except DONE.
- `Busy` is 1 in HEADER, LOAD, DRAIN and CHECK.
- `Done` is 1 only in DONE. `Error` is 1 only in ERROR.
- `Start` while `Busy` is ignored.
- `Start` in DONE re-asserts `CpuHold` on the next edge and reloads.
- Instruction memory contents are never cleared by the loader.

## Timing
- Reset values: state IDLE, `CpuHold`=1, all other outputs 0, word index 0, byte counter 0, checksum accumulator 0.
- Reset mid-load: on that edge, return to IDLE with reset values. Words already written remain in memory.
- `WriteEnable`, `WriteAddress` and `WriteData` are registered:
  - asserted for exactly one cycle, in the cycle after the edge that accepts byte 3 of a word
  - `WriteAddress` and `WriteData` hold their values after the strobe until the next write
- Latency: final byte accepted at edge T → final `WriteEnable` high in cycle T+1 (the DRAIN cycle).
  - Non-checksum build: DONE entered at edge T+1, so `CpuHold` falls in cycle T+2. The core never runs while the final write is pending.
- Stalls: the source may drop `ByteValid` at any cycle. There is no timeout; the loader waits indefinitely.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - the CHECK state and an 8-bit accumulator are compiled in
  - the accumulator holds the mod-256 sum of the header and all payload bytes
  - the trailer byte must equal this sum, otherwise → ERROR
  - ERROR keeps `CpuHold`=1 and sets `Error`=1 until `Start` or `reset`
- Undefined:
  - no CHECK state, no accumulator, no trailer byte
  - `Error` is tied 0
  - DRAIN → DONE directly

## Structure
- Shared package `mips_pkg`:
  - loader state enum (IDLE, HEADER, LOAD, DRAIN, CHECK, DONE, ERROR)
  - `IMEM_WORDS` and `IMEM_ADDR_WIDTH` constants, shared with the instruction memory
- Sub-module `imem_word_assembler`: byte shift register plus 2-bit byte counter.
  - Emits a one-cycle `WordValid` pulse with the 32-bit word.
  - The top level owns the FSM, word index, checksum and outputs.

## Test plan
- Reset then idle: `CpuHold`=1, `ByteReady`=0, no `WriteEnable` for 20 cycles without `Start`.
- Load N=2 with bytes 20 08 00 05, 00 00 00 00:
  - writes 0x20080005 to address 0 and 0x00000000 to address 1
  - `Done`=1 and `CpuHold`=0 two cycles after the last byte is accepted
- Header 0x00 with 256 payload bytes of address-indexed words: 64 writes, addresses 0..63, final write at 0x3F, no extra write.
- Randomly deasserted `ByteValid` (50 % duty) plus `Start` pulsed mid-load: same memory image as the unstalled run, and `Start` has no effect.
- `reset` asserted after 5 bytes of an N=3 load: IDLE next cycle, `CpuHold`=1. A fresh `Start` reloads from address 0.
- `IMEM_LOADER_CHECKSUM_EN`:
  - N=1, word 0x01020304, trailer 0x0B → `Done`
  - trailer 0x0C → `Error`=1, `CpuHold` stays 1
